// File: rtl/rs_dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rs_dispatch_queue
//  Description : Reservation-station array for one functional unit. Accepts
//                renamed instructions, snoops the CDB to wake waiting operands,
//                and issues the lowest-index ready entry into a registered
//                valid/ready output slot feeding the FU.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_dispatch_queue #(
  parameter int DATA_WIDTH  = 16,
  parameter int TAG_WIDTH   = 3,
  parameter int NUM_ENTRIES = 4,
  parameter int OP_WIDTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  // issue / allocation
  input  logic                                 alloc_valid,
  output logic                                 alloc_ready,
  input  logic [OP_WIDTH-1:0]                  alloc_op,
  input  logic [TAG_WIDTH-1:0]                 alloc_dest,
  input  logic [DATA_WIDTH-1:0]                alloc_vj,
  input  logic [DATA_WIDTH-1:0]                alloc_vk,
  input  logic [TAG_WIDTH-1:0]                 alloc_qj,
  input  logic [TAG_WIDTH-1:0]                 alloc_qk,
  input  logic                                 alloc_vj_valid,
  input  logic                                 alloc_vk_valid,
  // common data bus snoop
  input  logic                                 cdb_valid,
  input  logic [TAG_WIDTH-1:0]                 cdb_tag,
  input  logic [DATA_WIDTH-1:0]                cdb_data,
  // functional unit output slot
  output logic                                 fu_valid,
  input  logic                                 fu_ready,
  output logic [OP_WIDTH-1:0]                  fu_op,
  output logic [TAG_WIDTH-1:0]                 fu_dest,
  output logic [DATA_WIDTH-1:0]                fu_vj,
  output logic [DATA_WIDTH-1:0]                fu_vk,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]     free_count
);

  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  // Entry state
  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [NUM_ENTRIES-1:0] vjv_q, vjv_d;
  logic [NUM_ENTRIES-1:0] vkv_q, vkv_d;
  logic [OP_WIDTH-1:0]    op_q   [NUM_ENTRIES];
  logic [OP_WIDTH-1:0]    op_d   [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   dest_q [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   dest_d [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  vj_q   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  vj_d   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  vk_q   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  vk_d   [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   qj_q   [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   qj_d   [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   qk_q   [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   qk_d   [NUM_ENTRIES];

  // Output slot state
  logic                   fu_valid_q, fu_valid_d;
  logic [OP_WIDTH-1:0]    fu_op_q,    fu_op_d;
  logic [TAG_WIDTH-1:0]   fu_dest_q,  fu_dest_d;
  logic [DATA_WIDTH-1:0]  fu_vj_q,    fu_vj_d;
  logic [DATA_WIDTH-1:0]  fu_vk_q,    fu_vk_d;

  // Combinational helpers
  logic [NUM_ENTRIES-1:0] ready;
  logic [NUM_ENTRIES-1:0] alloc_oh;
  logic [NUM_ENTRIES-1:0] sel_oh;
  logic                   alloc_found;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [CNT_W-1:0]       free_cnt;
  logic                   alloc_fire;
  logic                   dispatch;
  logic                   byp_j;
  logic                   byp_k;

  assign ready = busy_q & vjv_q & vkv_q;

  // Priority pick of the lowest free slot (allocation) and lowest ready slot (issue)
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    sel_oh      = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!busy_q[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
      if (ready[i] && !sel_found) begin
        sel_oh[i] = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Free-entry count from registered busy bits only, so it never sees same-cycle frees
  always_comb begin
    free_cnt = CNT_W'(NUM_ENTRIES);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (busy_q[i]) free_cnt = free_cnt - CNT_W'(1);
    end
  end

  assign free_count  = free_cnt;
  assign alloc_ready = (free_cnt != '0);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign dispatch    = sel_found & (~fu_valid_q | fu_ready);

  // An operand arriving on the CDB in the allocation cycle is captured directly
  assign byp_j = cdb_valid & ~alloc_vj_valid & (alloc_qj == cdb_tag);
  assign byp_k = cdb_valid & ~alloc_vk_valid & (alloc_qk == cdb_tag);

  // Next-state: wakeup, dispatch free, allocation write, output slot, flush override
  always_comb begin
    busy_d     = busy_q;
    vjv_d      = vjv_q;
    vkv_d      = vkv_q;
    op_d       = op_q;
    dest_d     = dest_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    fu_valid_d = fu_valid_q;
    fu_op_d    = fu_op_q;
    fu_dest_d  = fu_dest_q;
    fu_vj_d    = fu_vj_q;
    fu_vk_d    = fu_vk_q;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (busy_q[i] && !vjv_q[i] && cdb_valid && (qj_q[i] == cdb_tag)) begin
        vj_d[i]  = cdb_data;
        vjv_d[i] = 1'b1;
      end
      if (busy_q[i] && !vkv_q[i] && cdb_valid && (qk_q[i] == cdb_tag)) begin
        vk_d[i]  = cdb_data;
        vkv_d[i] = 1'b1;
      end
      if (dispatch && sel_oh[i]) begin
        busy_d[i] = 1'b0;
      end
      // alloc_oh only marks a slot that is free in registered state, so it
      // never collides with a dispatch or wakeup on the same entry
      if (alloc_fire && alloc_oh[i]) begin
        busy_d[i] = 1'b1;
        op_d[i]   = alloc_op;
        dest_d[i] = alloc_dest;
        qj_d[i]   = alloc_qj;
        qk_d[i]   = alloc_qk;
        vj_d[i]   = byp_j ? cdb_data : alloc_vj;
        vk_d[i]   = byp_k ? cdb_data : alloc_vk;
        vjv_d[i]  = alloc_vj_valid | byp_j;
        vkv_d[i]  = alloc_vk_valid | byp_k;
      end
    end

    if (dispatch) begin
      fu_valid_d = 1'b1;
      fu_op_d    = op_q[sel_idx];
      fu_dest_d  = dest_q[sel_idx];
      fu_vj_d    = vj_q[sel_idx];
      fu_vk_d    = vk_q[sel_idx];
    end else if (fu_ready) begin
      fu_valid_d = 1'b0;
    end

    if (flush) begin
      busy_d     = '0;
      vjv_d      = '0;
      vkv_d      = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_d[i]   = '0;
        dest_d[i] = '0;
        vj_d[i]   = '0;
        vk_d[i]   = '0;
        qj_d[i]   = '0;
        qk_d[i]   = '0;
      end
      fu_valid_d = 1'b0;
      fu_op_d    = '0;
      fu_dest_d  = '0;
      fu_vj_d    = '0;
      fu_vk_d    = '0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      vjv_q      <= '0;
      vkv_q      <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
      end
      fu_valid_q <= 1'b0;
      fu_op_q    <= '0;
      fu_dest_q  <= '0;
      fu_vj_q    <= '0;
      fu_vk_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      vjv_q      <= vjv_d;
      vkv_q      <= vkv_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      fu_valid_q <= fu_valid_d;
      fu_op_q    <= fu_op_d;
      fu_dest_q  <= fu_dest_d;
      fu_vj_q    <= fu_vj_d;
      fu_vk_q    <= fu_vk_d;
    end
  end

  assign fu_valid = fu_valid_q;
  assign fu_op    = fu_op_q;
  assign fu_dest  = fu_dest_q;
  assign fu_vj    = fu_vj_q;
  assign fu_vk    = fu_vk_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_dispatch_queue
//  Description : Directed self-checking bench for rs_dispatch_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_dispatch_queue;

  localparam int DATA_WIDTH  = 16;
  localparam int TAG_WIDTH   = 3;
  localparam int NUM_ENTRIES = 4;
  localparam int OP_WIDTH    = 4;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [OP_WIDTH-1:0]   alloc_op;
  logic [TAG_WIDTH-1:0]  alloc_dest;
  logic [DATA_WIDTH-1:0] alloc_vj;
  logic [DATA_WIDTH-1:0] alloc_vk;
  logic [TAG_WIDTH-1:0]  alloc_qj;
  logic [TAG_WIDTH-1:0]  alloc_qk;
  logic                  alloc_vj_valid;
  logic                  alloc_vk_valid;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  fu_valid;
  logic                  fu_ready;
  logic [OP_WIDTH-1:0]   fu_op;
  logic [TAG_WIDTH-1:0]  fu_dest;
  logic [DATA_WIDTH-1:0] fu_vj;
  logic [DATA_WIDTH-1:0] fu_vk;
  logic [2:0]            free_count;

  int checks;
  int failures;

  rs_dispatch_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .NUM_ENTRIES(NUM_ENTRIES),
    .OP_WIDTH   (OP_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_op      (alloc_op),
    .alloc_dest    (alloc_dest),
    .alloc_vj      (alloc_vj),
    .alloc_vk      (alloc_vk),
    .alloc_qj      (alloc_qj),
    .alloc_qk      (alloc_qk),
    .alloc_vj_valid(alloc_vj_valid),
    .alloc_vk_valid(alloc_vk_valid),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .fu_valid      (fu_valid),
    .fu_ready      (fu_ready),
    .fu_op         (fu_op),
    .fu_dest       (fu_dest),
    .fu_vj         (fu_vj),
    .fu_vk         (fu_vk),
    .free_count    (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_alloc(input logic [3:0] op, input logic [2:0] dest,
                           input logic [15:0] vj, input logic vjv, input logic [2:0] qj,
                           input logic [15:0] vk, input logic vkv, input logic [2:0] qk);
    alloc_valid    = 1'b1;
    alloc_op       = op;
    alloc_dest     = dest;
    alloc_vj       = vj;
    alloc_vj_valid = vjv;
    alloc_qj       = qj;
    alloc_vk       = vk;
    alloc_vk_valid = vkv;
    alloc_qk       = qk;
  endtask

  task automatic do_alloc(input logic [3:0] op, input logic [2:0] dest,
                          input logic [15:0] vj, input logic vjv, input logic [2:0] qj,
                          input logic [15:0] vk, input logic vkv, input logic [2:0] qk);
    set_alloc(op, dest, vj, vjv, qj, vk, vkv, qk);
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    flush = 1'b0;
    alloc_valid = 1'b0;
    alloc_op = '0; alloc_dest = '0; alloc_vj = '0; alloc_vk = '0;
    alloc_qj = '0; alloc_qk = '0; alloc_vj_valid = 1'b0; alloc_vk_valid = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    fu_ready = 1'b1;
    #12;
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_free_count", free_count, 4);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_fu_dest", fu_dest, 0);
    chk("rst_fu_vj", fu_vj, 0);

    // Both operands present: 2-cycle alloc-to-dispatch latency
    do_alloc(4'h1, 3'd2, 16'h0005, 1'b1, 3'd0, 16'h0003, 1'b1, 3'd0);
    chk("t1_free_after_alloc", free_count, 3);
    chk("t1_valid_early", fu_valid, 0);
    tick();
    chk("t1_fu_valid", fu_valid, 1);
    chk("t1_fu_vj", fu_vj, 16'h0005);
    chk("t1_fu_vk", fu_vk, 16'h0003);
    chk("t1_fu_dest", fu_dest, 2);
    chk("t1_fu_op", fu_op, 1);
    chk("t1_free_count", free_count, 4);
    tick();
    chk("t1_drop", fu_valid, 0);

    // CDB wakeup of a waiting vj
    do_alloc(4'h5, 3'd1, 16'h0000, 1'b0, 3'd5, 16'h0007, 1'b1, 3'd0);
    chk("t2_free", free_count, 3);
    tick(); tick(); tick();
    chk("t2_waiting", fu_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'hBEEF;
    tick();
    cdb_valid = 1'b0;
    chk("t2_not_yet", fu_valid, 0);
    tick();
    chk("t2_fu_valid", fu_valid, 1);
    chk("t2_fu_vj", fu_vj, 16'hBEEF);
    chk("t2_fu_vk", fu_vk, 16'h0007);
    chk("t2_fu_dest", fu_dest, 1);
    tick();
    chk("t2_drop", fu_valid, 0);
    chk("t2_hold_vj", fu_vj, 16'hBEEF);
    chk("t2_free_back", free_count, 4);

    // Same-cycle alloc/CDB bypass on vk
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h1234;
    do_alloc(4'h1, 3'd3, 16'h0011, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd6);
    cdb_valid = 1'b0;
    tick();
    chk("t3_fu_valid", fu_valid, 1);
    chk("t3_fu_vk", fu_vk, 16'h1234);
    chk("t3_fu_vj", fu_vj, 16'h0011);
    chk("t3_fu_dest", fu_dest, 3);
    tick();

    // Fill all entries with waiting instructions
    do_alloc(4'h1, 3'd4, 16'h0000, 1'b0, 3'd1, 16'h00A0, 1'b1, 3'd0);
    do_alloc(4'h1, 3'd5, 16'h0000, 1'b0, 3'd2, 16'h00A1, 1'b1, 3'd0);
    do_alloc(4'h1, 3'd6, 16'h00B2, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd1);
    do_alloc(4'h1, 3'd7, 16'h0000, 1'b0, 3'd3, 16'h00A3, 1'b1, 3'd0);
    chk("t4_full_free", free_count, 0);
    chk("t4_full_ready", alloc_ready, 0);
    // Fifth alloc is a ready instruction; it must be dropped, not overwrite
    do_alloc(4'h9, 3'd0, 16'h0F0F, 1'b1, 3'd0, 16'h0F0F, 1'b1, 3'd0);
    chk("t4_drop_free", free_count, 0);
    tick();
    chk("t4_drop_no_issue", fu_valid, 0);
    // Wake entries 0 (qj=1) and 2 (qk=1) together
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'hCAFE;
    tick();
    cdb_valid = 1'b0;
    chk("t4_wake_not_yet", fu_valid, 0);
    tick();
    chk("t4_first_valid", fu_valid, 1);
    chk("t4_first_dest", fu_dest, 4);
    chk("t4_first_vj", fu_vj, 16'hCAFE);
    chk("t4_first_vk", fu_vk, 16'h00A0);
    chk("t4_first_free", free_count, 1);
    tick();
    chk("t4_second_dest", fu_dest, 6);
    chk("t4_second_vj", fu_vj, 16'h00B2);
    chk("t4_second_vk", fu_vk, 16'hCAFE);
    chk("t4_second_free", free_count, 2);
    tick();
    chk("t4_empty", fu_valid, 0);

    // Backpressure: entries 1 (qj=2) and 3 (qj=3) remain busy
    fu_ready = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h1111;
    tick();
    cdb_tag = 3'd3; cdb_data = 16'h3333;
    tick();
    cdb_valid = 1'b0;
    chk("t5_slot_valid", fu_valid, 1);
    chk("t5_slot_dest", fu_dest, 5);
    chk("t5_free", free_count, 3);
    do_alloc(4'h2, 3'd2, 16'h2222, 1'b1, 3'd0, 16'h0002, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", fu_valid, 1);
      chk("t5_hold_dest", fu_dest, 5);
      chk("t5_hold_vj", fu_vj, 16'h1111);
      chk("t5_hold_vk", fu_vk, 16'h00A1);
      chk("t5_hold_free", free_count, 2);
    end
    fu_ready = 1'b1;
    tick();
    chk("t5_bb1_valid", fu_valid, 1);
    chk("t5_bb1_dest", fu_dest, 2);
    chk("t5_bb1_vj", fu_vj, 16'h2222);
    chk("t5_bb1_op", fu_op, 2);
    tick();
    chk("t5_bb2_valid", fu_valid, 1);
    chk("t5_bb2_dest", fu_dest, 7);
    chk("t5_bb2_vj", fu_vj, 16'h3333);
    chk("t5_bb2_vk", fu_vk, 16'h00A3);
    tick();
    chk("t5_drain_valid", fu_valid, 0);
    chk("t5_drain_free", free_count, 4);

    // Flush with three busy entries and an occupied output slot
    fu_ready = 1'b0;
    do_alloc(4'h1, 3'd1, 16'h0001, 1'b1, 3'd0, 16'h0001, 1'b1, 3'd0);
    do_alloc(4'h1, 3'd2, 16'h0000, 1'b0, 3'd4, 16'h0001, 1'b1, 3'd0);
    do_alloc(4'h1, 3'd3, 16'h0000, 1'b0, 3'd4, 16'h0001, 1'b1, 3'd0);
    do_alloc(4'h1, 3'd5, 16'h0000, 1'b0, 3'd4, 16'h0001, 1'b1, 3'd0);
    chk("t6_pre_valid", fu_valid, 1);
    chk("t6_pre_dest", fu_dest, 1);
    chk("t6_pre_free", free_count, 1);
    flush = 1'b1;
    set_alloc(4'h1, 3'd6, 16'h0042, 1'b1, 3'd0, 16'h0042, 1'b1, 3'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h5555;
    fu_ready = 1'b1;
    tick();
    flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
    chk("t6_fu_valid", fu_valid, 0);
    chk("t6_free", free_count, 4);
    chk("t6_alloc_ready", alloc_ready, 1);
    chk("t6_fu_dest", fu_dest, 0);
    chk("t6_fu_vj", fu_vj, 0);
    tick();
    chk("t6_still_empty", fu_valid, 0);
    chk("t6_still_free", free_count, 4);

    // Asynchronous reset mid-cycle
    do_alloc(4'h3, 3'd3, 16'h0077, 1'b1, 3'd0, 16'h0088, 1'b1, 3'd0);
    do_alloc(4'h1, 3'd4, 16'h0000, 1'b0, 3'd2, 16'h0001, 1'b1, 3'd0);
    chk("t7_pre_valid", fu_valid, 1);
    chk("t7_pre_vj", fu_vj, 16'h0077);
    chk("t7_pre_free", free_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_valid", fu_valid, 0);
    chk("t7_async_dest", fu_dest, 0);
    chk("t7_async_vj", fu_vj, 0);
    chk("t7_async_op", fu_op, 0);
    chk("t7_async_free", free_count, 4);
    chk("t7_async_ready", alloc_ready, 1);
    #2;
    rst = 1'b0;
    tick();
    chk("t7_post_valid", fu_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
